batch_gradient_packetizer: RTL

- Transmit-side counterpart of the batch gradient adder path. Takes 512-bit gradient lines (16 x FP32 lanes) from the update/broadcast logic and serialises them into a 32-bit AXI-Stream toward the TCP/IP stack TX data interface.
- Marks the end of each batch with TLAST. Honours TREADY backpressure and keeps full throughput of 1 word/cycle.

---
 rtl/batch_gradient_packetizer_if.sv | 32 +++
 rtl/batch_gradient_packetizer.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/batch_gradient_packetizer_if.sv
// Gradient line input stream and 32-bit TX output stream of the packetizer.
// Modport slave is the packetizer's view; master is the view of whatever
// sits on the other side of both streams (update logic and TCP/IP TX).
interface batch_gradient_packetizer_if #(
    parameter int FLOAT_SIZE = 32,
    parameter int PIPE_SIZE  = 16
);
    logic [FLOAT_SIZE*PIPE_SIZE-1:0] s_axis_line_TDATA;
    logic [$clog2(PIPE_SIZE):0]      s_axis_line_TWORDS;
    logic                            s_axis_line_TLAST;
    logic                            s_axis_line_TVALID;
    logic                            s_axis_line_TREADY;

    logic [FLOAT_SIZE-1:0]           m_axis_tx_TDATA;
    logic                            m_axis_tx_TVALID;
    logic                            m_axis_tx_TLAST;
    logic                            m_axis_tx_TREADY;

    modport slave (
        input  s_axis_line_TDATA, s_axis_line_TWORDS, s_axis_line_TLAST, s_axis_line_TVALID,
        output s_axis_line_TREADY,
        output m_axis_tx_TDATA, m_axis_tx_TVALID, m_axis_tx_TLAST,
        input  m_axis_tx_TREADY
    );

    modport master (
        output s_axis_line_TDATA, s_axis_line_TWORDS, s_axis_line_TLAST, s_axis_line_TVALID,
        input  s_axis_line_TREADY,
        input  m_axis_tx_TDATA, m_axis_tx_TVALID, m_axis_tx_TLAST,
        output m_axis_tx_TREADY
    );
endinterface

// File: rtl/batch_gradient_packetizer.sv
// Serialises 16 x FP32 gradient lines into a 32-bit stream, lane 0 first,
// with TLAST on the final word of each batch and 1 word/cycle throughput.
// Optional feature: define BATCH_HEADER_EN to prefix every batch with one
// header word {batch_seq[15:0], 16'hB47C}.
//
// state | meaning
// IDLE  | no word pending, line input ready
// SEND  | presenting lane idx of the buffered line
// HDR   | presenting the batch header word (BATCH_HEADER_EN only)
module batch_gradient_packetizer #(
    parameter int FLOAT_SIZE = 32,
    parameter int PIPE_SIZE  = 16,
    parameter int SEQ_BITS   = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    batch_gradient_packetizer_if.slave bus,
    output logic                    batch_done,
    output logic [SEQ_BITS-1:0]     batch_seq
);
    localparam int LINE_W = FLOAT_SIZE * PIPE_SIZE;
    localparam int IDX_W  = $clog2(PIPE_SIZE);
    localparam int CNT_W  = IDX_W + 1;

`ifdef BATCH_HEADER_EN
    typedef enum logic [1:0] {IDLE, SEND, HDR} state_t;
`else
    typedef enum logic [1:0] {IDLE, SEND} state_t;
`endif

    state_t                state;
    logic [LINE_W-1:0]     line_buf;
    logic [CNT_W-1:0]      n_words;
    logic [IDX_W-1:0]      idx;
    logic                  last_flag;
    logic [FLOAT_SIZE-1:0] tx_data;
    logic                  tx_valid;
    logic                  tx_last;
`ifdef BATCH_HEADER_EN
    logic                  batch_start;
`endif

    logic [FLOAT_SIZE-1:0] buf_lanes [PIPE_SIZE];
    logic [FLOAT_SIZE-1:0] in_lane0;
    logic [CNT_W-1:0]      in_words;
    logic [IDX_W-1:0]      next_idx;
    logic                  is_final;
    logic                  next_last;
    logic                  first_last;
    logic                  tx_fire;
    logic                  line_ready;
    logic                  line_fire;

`ifdef BATCH_HEADER_EN
    function automatic logic [FLOAT_SIZE-1:0] hdr_word(input logic [SEQ_BITS-1:0] seq);
        return {seq[15:0], 16'hB47C};
    endfunction
`endif

    // Lane view of the line buffer so the word mux indexes by idx directly.
    always_comb begin
        for (int k = 0; k < PIPE_SIZE; k++) begin
            buf_lanes[k] = line_buf[k*FLOAT_SIZE +: FLOAT_SIZE];
        end
    end

    // Word-count clamp, handshakes and the combinational line-ready path.
    // Ready on the final word lets the next line follow with no bubble.
    always_comb begin
        in_words   = (bus.s_axis_line_TWORDS == '0 || bus.s_axis_line_TWORDS > CNT_W'(PIPE_SIZE))
                     ? CNT_W'(PIPE_SIZE) : bus.s_axis_line_TWORDS;
        in_lane0   = bus.s_axis_line_TDATA[FLOAT_SIZE-1:0];
        first_last = bus.s_axis_line_TLAST && (in_words == CNT_W'(1));
        next_idx   = idx + IDX_W'(1);
        is_final   = ({1'b0, idx} == n_words - CNT_W'(1));
        next_last  = last_flag && ({1'b0, next_idx} == n_words - CNT_W'(1));
        tx_fire    = tx_valid && bus.m_axis_tx_TREADY;
        line_ready = (state == IDLE) || (state == SEND && bus.m_axis_tx_TREADY && is_final);
        line_fire  = bus.s_axis_line_TVALID && line_ready;
    end

    assign bus.s_axis_line_TREADY = line_ready;
    assign bus.m_axis_tx_TDATA    = tx_data;
    assign bus.m_axis_tx_TVALID   = tx_valid;
    assign bus.m_axis_tx_TLAST    = tx_last;

    // Sequencer: line capture, word stepping, batch completion bookkeeping.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            line_buf   <= '0;
            n_words    <= '0;
            idx        <= '0;
            last_flag  <= 1'b0;
            tx_data    <= '0;
            tx_valid   <= 1'b0;
            tx_last    <= 1'b0;
            batch_done <= 1'b0;
            batch_seq  <= '0;
`ifdef BATCH_HEADER_EN
            batch_start <= 1'b1;
`endif
        end else begin
            batch_done <= tx_fire && tx_last;
            if (tx_fire && tx_last) begin
                batch_seq <= batch_seq + SEQ_BITS'(1);
`ifdef BATCH_HEADER_EN
                batch_start <= 1'b1;
`endif
            end

            if (line_fire) begin
                line_buf  <= bus.s_axis_line_TDATA;
                n_words   <= in_words;
                last_flag <= bus.s_axis_line_TLAST;
                idx       <= '0;
            end

            case (state)
                IDLE: begin
                    if (line_fire) begin
                        tx_valid <= 1'b1;
`ifdef BATCH_HEADER_EN
                        if (batch_start) begin
                            state       <= HDR;
                            tx_data     <= hdr_word(batch_seq);
                            tx_last     <= 1'b0;
                            batch_start <= 1'b0;
                        end else begin
                            state   <= SEND;
                            tx_data <= in_lane0;
                            tx_last <= first_last;
                        end
`else
                        state   <= SEND;
                        tx_data <= in_lane0;
                        tx_last <= first_last;
`endif
                    end
                end
                SEND: begin
                    if (tx_fire) begin
                        if (!is_final) begin
                            idx     <= next_idx;
                            tx_data <= buf_lanes[next_idx];
                            tx_last <= next_last;
                        end else if (line_fire) begin
`ifdef BATCH_HEADER_EN
                            // A line arriving with the TLAST word opens a new batch.
                            if (tx_last) begin
                                state       <= HDR;
                                tx_data     <= hdr_word(batch_seq + SEQ_BITS'(1));
                                tx_last     <= 1'b0;
                                batch_start <= 1'b0;
                            end else begin
                                tx_data <= in_lane0;
                                tx_last <= first_last;
                            end
`else
                            tx_data <= in_lane0;
                            tx_last <= first_last;
`endif
                        end else begin
                            state    <= IDLE;
                            tx_valid <= 1'b0;
                            tx_last  <= 1'b0;
                        end
                    end
                end
`ifdef BATCH_HEADER_EN
                HDR: begin
                    if (tx_fire) begin
                        state   <= SEND;
                        tx_data <= buf_lanes[0];
                        tx_last <= last_flag && (n_words == CNT_W'(1));
                    end
                end
`endif
                default: begin
                    state    <= IDLE;
                    tx_valid <= 1'b0;
                    tx_last  <= 1'b0;
                end
            endcase
        end
    end
endmodule
